// File: rtl/idu_operand_stage_pkg.sv
// Shared decode constants for the operand stage: opcodes, funct3 values,
// the ebreak encoding, adder operand select codes and immediate formats.
package idu_operand_stage_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    // Left adder operand select
    localparam logic [1:0] LSEL_SRC1 = 2'd0;
    localparam logic [1:0] LSEL_PC   = 2'd1;
    localparam logic [1:0] LSEL_ZERO = 2'd2;

    // Right adder operand select
    localparam logic [1:0] RSEL_IMM  = 2'd0;
    localparam logic [1:0] RSEL_FOUR = 2'd1;
    localparam logic [1:0] RSEL_ZERO = 2'd2;

    // Immediate formats; IMM_NONE yields a zero immediate
    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_I    = 2'd1,
        IMM_U    = 2'd2,
        IMM_J    = 2'd3
    } imm_type_e;

    // Build the 32-bit sign-extended immediate for the given format.
    function automatic logic [31:0] build_imm32(input imm_type_e t, input logic [31:0] inst);
        logic [31:0] r;
        r = '0;
        case (t)
            IMM_I:   r = {{20{inst[31]}}, inst[31:20]};
            IMM_U:   r = {inst[31:12], 12'b0};
            IMM_J:   r = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/idu_operand_stage_gpr_file.sv
// General-purpose register file: one combinational read port, one write
// port committed at the rising edge, asynchronous clear, x0 reads as zero.
module idu_operand_stage_gpr_file #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_IDX_W  = 5,
    parameter int NR_REGS    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_IDX_W-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  we,
    input  logic [REG_IDX_W-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata
);

    logic [NR_REGS-1:0][DATA_WIDTH-1:0] regs_q;
    logic [NR_REGS-1:0][DATA_WIDTH-1:0] regs_d;

    // Next register contents: apply the write unless it targets x0
    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
        regs_d[0] = '0;
    end

    // Register storage, cleared on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Combinational read; a same-cycle write is not visible until the edge
    always_comb begin
        rdata = (raddr == '0) ? '0 : regs_q[raddr];
    end

endmodule

// File: rtl/idu_operand_stage.sv
// Decode / operand stage feeding the adder execute stage. Decodes one
// instruction, reads rs1, tracks outstanding writers in a busy scoreboard
// and registers operands plus adder select codes.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// A producer holding valid keeps its payload stable until the transfer;
// in_ready depends combinationally on out_ready and on the RAW/WAW hazard.
//
// Optional feature macro: IDU_WB_BYPASS_EN -- forwards a same-cycle
// writeback to rs1 so a RAW dependency on it does not stall.
module idu_operand_stage
    import idu_operand_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,   // must be >= 32
    parameter int REG_IDX_W  = 5,
    parameter int NR_REGS    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_inst,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic                  wb_en,
    input  logic [REG_IDX_W-1:0]  wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_src1,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [1:0]            out_left_opt,
    output logic [1:0]            out_right_opt,
    output logic [REG_IDX_W-1:0]  out_rd,
    output logic                  out_wen,
    output logic                  out_ebreak,
    output logic                  out_illegal
);

    // Instruction fields
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [REG_IDX_W-1:0] rs1_idx;
    logic [REG_IDX_W-1:0] rd_idx;

    // Decode results
    logic                  dec_writes;
    logic                  dec_wen;
    logic                  dec_ebreak;
    logic                  dec_illegal;
    logic [1:0]            dec_lsel;
    logic [1:0]            dec_rsel;
    imm_type_e             dec_imm_type;
    logic [DATA_WIDTH-1:0] dec_imm;
    logic [REG_IDX_W-1:0]  dec_rd;

    // Operand / hazard
    logic [DATA_WIDTH-1:0] gpr_rdata;
    logic [DATA_WIDTH-1:0] src1_val;
    logic                  raw_hazard;
    logic                  waw_hazard;
    logic                  hazard;
    logic                  accept;
    logic                  wb_commit;

    // Scoreboard and output registers
    logic [NR_REGS-1:0]    busy_q, busy_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_src1_q, out_src1_d;
    logic [DATA_WIDTH-1:0] out_imm_q, out_imm_d;
    logic [DATA_WIDTH-1:0] out_pc_q, out_pc_d;
    logic [1:0]            out_left_opt_q, out_left_opt_d;
    logic [1:0]            out_right_opt_q, out_right_opt_d;
    logic [REG_IDX_W-1:0]  out_rd_q, out_rd_d;
    logic                  out_wen_q, out_wen_d;
    logic                  out_ebreak_q, out_ebreak_d;
    logic                  out_illegal_q, out_illegal_d;

    assign opcode  = in_inst[6:0];
    assign funct3  = in_inst[14:12];
    assign rs1_idx = in_inst[15 +: REG_IDX_W];
    assign rd_idx  = in_inst[7 +: REG_IDX_W];

    // Decode opcode/funct3 into select codes, immediate format and flags
    always_comb begin
        dec_lsel     = LSEL_ZERO;
        dec_rsel     = RSEL_ZERO;
        dec_imm_type = IMM_NONE;
        dec_writes   = 1'b0;
        dec_ebreak   = 1'b0;
        dec_illegal  = 1'b0;
        if (in_inst == EBREAK_INST) begin
            dec_ebreak = 1'b1;
        end else begin
            case (opcode)
                OPC_OP_IMM: begin
                    if (funct3 == F3_ADDI) begin
                        dec_lsel     = LSEL_SRC1;
                        dec_rsel     = RSEL_IMM;
                        dec_imm_type = IMM_I;
                        dec_writes   = 1'b1;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
                OPC_LUI: begin
                    dec_lsel     = LSEL_ZERO;
                    dec_rsel     = RSEL_IMM;
                    dec_imm_type = IMM_U;
                    dec_writes   = 1'b1;
                end
                OPC_AUIPC: begin
                    dec_lsel     = LSEL_PC;
                    dec_rsel     = RSEL_IMM;
                    dec_imm_type = IMM_U;
                    dec_writes   = 1'b1;
                end
                OPC_JAL: begin
                    dec_lsel     = LSEL_PC;
                    dec_rsel     = RSEL_FOUR;
                    dec_imm_type = IMM_J;
                    dec_writes   = 1'b1;
                end
                OPC_JALR: begin
                    if (funct3 == F3_JALR) begin
                        dec_lsel     = LSEL_PC;
                        dec_rsel     = RSEL_FOUR;
                        dec_imm_type = IMM_I;
                        dec_writes   = 1'b1;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    // Sign-extend the immediate; writes to x0 are architecturally dropped
    always_comb begin
        dec_imm = DATA_WIDTH'($signed(build_imm32(dec_imm_type, in_inst)));
        dec_wen = dec_writes && (rd_idx != '0);
        dec_rd  = dec_writes ? rd_idx : '0;
    end

    idu_operand_stage_gpr_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_IDX_W  (REG_IDX_W),
        .NR_REGS    (NR_REGS)
    ) u_gpr_file (
        .clk   (clk),
        .rst   (rst),
        .raddr (rs1_idx),
        .rdata (gpr_rdata),
        .we    (wb_en),
        .waddr (wb_rd),
        .wdata (wb_data)
    );

    assign wb_commit = wb_en && (wb_rd != '0);

    // RAW/WAW interlock and rs1 operand selection
`ifdef IDU_WB_BYPASS_EN
    always_comb begin
        logic bypass_hit;
        bypass_hit = wb_commit && (wb_rd == rs1_idx);
        raw_hazard = (dec_lsel == LSEL_SRC1) && busy_q[rs1_idx] && !bypass_hit;
        src1_val   = bypass_hit ? wb_data : gpr_rdata;
    end
`else
    always_comb begin
        raw_hazard = (dec_lsel == LSEL_SRC1) && busy_q[rs1_idx];
        src1_val   = gpr_rdata;
    end
`endif

    // Ready/accept: pipeline slot free and no outstanding conflicting writer
    always_comb begin
        waw_hazard = dec_wen && busy_q[rd_idx];
        hazard     = raw_hazard || waw_hazard;
        in_ready   = (!out_valid_q || out_ready) && !hazard;
        accept     = in_valid && in_ready;
    end

    // Next state for the output register and the busy scoreboard
    always_comb begin
        out_valid_d     = out_valid_q;
        out_src1_d      = out_src1_q;
        out_imm_d       = out_imm_q;
        out_pc_d        = out_pc_q;
        out_left_opt_d  = out_left_opt_q;
        out_right_opt_d = out_right_opt_q;
        out_rd_d        = out_rd_q;
        out_wen_d       = out_wen_q;
        out_ebreak_d    = out_ebreak_q;
        out_illegal_d   = out_illegal_q;
        busy_d          = busy_q;

        if (accept) begin
            out_valid_d     = 1'b1;
            out_src1_d      = (dec_lsel == LSEL_SRC1) ? src1_val : '0;
            out_imm_d       = dec_imm;
            out_pc_d        = in_pc;
            out_left_opt_d  = dec_lsel;
            out_right_opt_d = dec_rsel;
            out_rd_d        = dec_rd;
            out_wen_d       = dec_wen;
            out_ebreak_d    = dec_ebreak;
            out_illegal_d   = dec_illegal;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Clear first, then set: the WAW stall keeps the two indices apart
        if (wb_commit) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (accept && dec_wen) begin
            busy_d[rd_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers; reset drops any held or stalled instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q     <= 1'b0;
            out_src1_q      <= '0;
            out_imm_q       <= '0;
            out_pc_q        <= '0;
            out_left_opt_q  <= '0;
            out_right_opt_q <= '0;
            out_rd_q        <= '0;
            out_wen_q       <= 1'b0;
            out_ebreak_q    <= 1'b0;
            out_illegal_q   <= 1'b0;
            busy_q          <= '0;
        end else begin
            out_valid_q     <= out_valid_d;
            out_src1_q      <= out_src1_d;
            out_imm_q       <= out_imm_d;
            out_pc_q        <= out_pc_d;
            out_left_opt_q  <= out_left_opt_d;
            out_right_opt_q <= out_right_opt_d;
            out_rd_q        <= out_rd_d;
            out_wen_q       <= out_wen_d;
            out_ebreak_q    <= out_ebreak_d;
            out_illegal_q   <= out_illegal_d;
            busy_q          <= busy_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_src1      = out_src1_q;
    assign out_imm       = out_imm_q;
    assign out_pc        = out_pc_q;
    assign out_left_opt  = out_left_opt_q;
    assign out_right_opt = out_right_opt_q;
    assign out_rd        = out_rd_q;
    assign out_wen       = out_wen_q;
    assign out_ebreak    = out_ebreak_q;
    assign out_illegal   = out_illegal_q;

endmodule

// File: tb/tb_idu_operand_stage.sv
// Directed bench for idu_operand_stage: a decode vector table plus
// hand-written sequences for RAW stall, backpressure, x0 writes and reset.
// Honours IDU_WB_BYPASS_EN when defined for the build.
module tb_idu_operand_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_src1;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic [1:0]  out_left_opt;
    logic [1:0]  out_right_opt;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_ebreak;
    logic        out_illegal;

    idu_operand_stage dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_inst       (in_inst),
        .in_pc         (in_pc),
        .wb_en         (wb_en),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_src1      (out_src1),
        .out_imm       (out_imm),
        .out_pc        (out_pc),
        .out_left_opt  (out_left_opt),
        .out_right_opt (out_right_opt),
        .out_rd        (out_rd),
        .out_wen       (out_wen),
        .out_ebreak    (out_ebreak),
        .out_illegal   (out_illegal)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [1:0]  l;
        logic [1:0]  r;
        logic [4:0]  rd;
        logic        wen;
        logic        ebreak;
        logic        illegal;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] gpr_m[32];
    logic [31:0] exp_q[$];
    int          n_checks;
    int          n_pass;

    // Scoreboard compare
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Writeback driver: one cycle, also updates the register model
    task automatic do_wb(input logic [4:0] rd, input logic [31:0] data);
        wb_en   = 1'b1;
        wb_rd   = rd;
        wb_data = data;
        if (rd != 5'd0) gpr_m[rd] = data;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic set_vec(input int i, input logic [31:0] inst, input logic [31:0] pc,
                           input logic [31:0] imm, input logic [1:0] l, input logic [1:0] r,
                           input logic [4:0] rd, input logic wen, input logic eb, input logic ill);
        vecs[i].inst = inst; vecs[i].pc = pc; vecs[i].imm = imm;
        vecs[i].l = l; vecs[i].r = r; vecs[i].rd = rd;
        vecs[i].wen = wen; vecs[i].ebreak = eb; vecs[i].illegal = ill;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_inst   = 32'h0;
        in_pc     = 32'h0;
        wb_en     = 1'b0;
        wb_rd     = 5'd0;
        wb_data   = 32'h0;
        out_ready = 1'b1;
        for (int k = 0; k < 32; k++) gpr_m[k] = 32'h0;

        //               inst          pc            imm           L  R  rd wen eb ill
        set_vec(0, 32'h00500093, 32'h80000000, 32'h00000005, 0, 0, 1, 1, 0, 0); // addi x1,x0,5
        set_vec(1, 32'h12345137, 32'h80000008, 32'h12345000, 2, 0, 2, 1, 0, 0); // lui x2
        set_vec(2, 32'h00001197, 32'h80000004, 32'h00001000, 1, 0, 3, 1, 0, 0); // auipc x3,1
        set_vec(3, 32'h008000ef, 32'h80000010, 32'h00000008, 1, 1, 1, 1, 0, 0); // jal x1,8
        set_vec(4, 32'h00100073, 32'h80000014, 32'h00000000, 2, 2, 0, 0, 1, 0); // ebreak
        set_vec(5, 32'hffffffff, 32'h80000018, 32'h00000000, 2, 2, 0, 0, 0, 1); // illegal
        set_vec(6, 32'h000002e7, 32'h8000001c, 32'h00000000, 1, 1, 5, 1, 0, 0); // jalr x5,0(x0)
        set_vec(7, 32'hfff00313, 32'h80000020, 32'hffffffff, 0, 0, 6, 1, 0, 0); // addi x6,x0,-1
        set_vec(8, 32'h00001037, 32'h80000024, 32'h00001000, 2, 0, 0, 0, 0, 0); // lui x0 -> no write
        set_vec(9, 32'h00501093, 32'h80000028, 32'h00000000, 2, 2, 0, 0, 0, 1); // op-imm f3=1

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_wen", {31'b0, out_wen}, 32'h0);
        chk("rst_out_imm", out_imm, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_busy", dut.busy_q, 32'h0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);

        // Decode table
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_inst  = vecs[i].inst;
            in_pc    = vecs[i].pc;
            #1;
            chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, 32'h1);
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'h1);
            chk($sformatf("v%0d_imm", i), out_imm, vecs[i].imm);
            chk($sformatf("v%0d_pc", i), out_pc, vecs[i].pc);
            chk($sformatf("v%0d_lsel", i), {30'b0, out_left_opt}, {30'b0, vecs[i].l});
            chk($sformatf("v%0d_rsel", i), {30'b0, out_right_opt}, {30'b0, vecs[i].r});
            chk($sformatf("v%0d_wen", i), {31'b0, out_wen}, {31'b0, vecs[i].wen});
            chk($sformatf("v%0d_ebreak", i), {31'b0, out_ebreak}, {31'b0, vecs[i].ebreak});
            chk($sformatf("v%0d_illegal", i), {31'b0, out_illegal}, {31'b0, vecs[i].illegal});
            if (vecs[i].wen) begin
                chk($sformatf("v%0d_rd", i), {27'b0, out_rd}, {27'b0, vecs[i].rd});
                chk($sformatf("v%0d_busy", i), {31'b0, dut.busy_q[vecs[i].rd]}, 32'h1);
            end
            if (vecs[i].l == 2'd0)
                chk($sformatf("v%0d_src1", i), out_src1, gpr_m[vecs[i].inst[19:15]]);
            if (vecs[i].wen) do_wb(vecs[i].rd, 32'h100 + i);
        end
        chk("table_busy_clear", dut.busy_q, 32'h0);

        // RAW stall: addi x1,x0,5 then addi x3,x1,1
        in_valid = 1'b1;
        in_inst  = 32'h00500093;
        in_pc    = 32'h80000000;
        tick();
        in_inst = 32'h00108193;
        in_pc   = 32'h80000004;
        #1;
        chk("raw_stall_ready", {31'b0, in_ready}, 32'h0);
        tick();
        chk("raw_stall_ready2", {31'b0, in_ready}, 32'h0);
        wb_en   = 1'b1;
        wb_rd   = 5'd1;
        wb_data = 32'd5;
        gpr_m[1] = 32'd5;
        #1;
`ifdef IDU_WB_BYPASS_EN
        chk("raw_bypass_ready", {31'b0, in_ready}, 32'h1);
        tick();
        wb_en = 1'b0;
`else
        chk("raw_wb_cycle_ready", {31'b0, in_ready}, 32'h0);
        tick();
        wb_en = 1'b0;
        #1;
        chk("raw_after_wb_ready", {31'b0, in_ready}, 32'h1);
        tick();
`endif
        in_valid = 1'b0;
        chk("raw_valid", {31'b0, out_valid}, 32'h1);
        chk("raw_rd", {27'b0, out_rd}, 32'd3);
        chk("raw_src1", out_src1, 32'd5);
        do_wb(5'd3, 32'd6);

        // Backpressure: hold A for 3 cycles while B waits
        in_valid = 1'b1;
        in_inst  = 32'h00700313;              // addi x6,x0,7
        exp_q.push_back(32'd7);
        tick();
        out_ready = 1'b0;
        in_inst   = 32'h12345137;             // lui x2,0x12345
        exp_q.push_back(32'h12345000);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_in_ready", c), {31'b0, in_ready}, 32'h0);
            tick();
            chk($sformatf("bp%0d_valid", c), {31'b0, out_valid}, 32'h1);
            chk($sformatf("bp%0d_imm", c), out_imm, exp_q[0]);
            chk($sformatf("bp%0d_rd", c), {27'b0, out_rd}, 32'd6);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'b0, in_ready}, 32'h1);
        void'(exp_q.pop_front());
        tick();
        in_valid = 1'b0;
        chk("bp_next_valid", {31'b0, out_valid}, 32'h1);
        chk("bp_next_imm", out_imm, exp_q.pop_front());
        chk("bp_next_rd", {27'b0, out_rd}, 32'd2);
        tick();
        chk("bp_no_dup", {31'b0, out_valid}, 32'h0);
        do_wb(5'd6, 32'd7);
        do_wb(5'd2, 32'h12345000);

        // Write to x0 is ignored
        do_wb(5'd0, 32'h0000dead);
        in_valid = 1'b1;
        in_inst  = 32'h00300393;              // addi x7,x0,3
        tick();
        in_valid = 1'b0;
        chk("x0_src1", out_src1, 32'h0);
        chk("x0_imm", out_imm, 32'd3);
        do_wb(5'd7, 32'd3);

        // Reset during RAW stall
        in_valid = 1'b1;
        in_inst  = 32'h00500093;
        tick();
        in_inst = 32'h00108193;
        #1;
        chk("rstall_ready", {31'b0, in_ready}, 32'h0);
        rst = 1'b1;
        #1;
        chk("rstall_valid", {31'b0, out_valid}, 32'h0);
        chk("rstall_busy", dut.busy_q, 32'h0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 32; k++) gpr_m[k] = 32'h0;
        #1;
        chk("rstall_ready_after", {31'b0, in_ready}, 32'h1);
        tick();
        in_valid = 1'b0;
        chk("rstall_acc_valid", {31'b0, out_valid}, 32'h1);
        chk("rstall_acc_rd", {27'b0, out_rd}, 32'd3);
        chk("rstall_acc_src1", out_src1, gpr_m[1]);
        chk("rstall_acc_imm", out_imm, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/idu_operand_stage.md
Name: idu_operand_stage

Overview:
- Decode/operand stage sitting directly upstream of the adder execute stage in the single-instruction CPU.
- Accepts a fetched instruction and its PC over a valid/ready handshake, then decodes it.
- Reads rs1 from an internal GPR file and registers the operands and adder select codes (left: src1/pc/zero; right: imm/4/zero) for the execute stage.
- Owns GPR writeback and a per-register busy scoreboard for RAW/WAW interlock.

Parameters:
- DATA_WIDTH, 32, datapath and GPR width.
- REG_IDX_W, 5, GPR index width.
- NR_REGS, 32, number of GPRs; x0 is hardwired to zero.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction/PC valid.
- in_ready  out  1  stage accepts this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  DATA_WIDTH  instruction address.
- wb_en  in  1  writeback strobe from the execute stage.
- wb_rd  in  REG_IDX_W  writeback destination.
- wb_data  in  DATA_WIDTH  writeback value.
- out_valid  out  1  registered outputs valid.
- out_ready  in  1  execute stage consumes.
- out_src1  out  DATA_WIDTH  rs1 value.
- out_imm  out  DATA_WIDTH  sign-extended immediate.
- out_pc  out  DATA_WIDTH  PC of the instruction.
- out_left_opt  out  2  0=src1, 1=pc, 2=zero.
- out_right_opt  out  2  0=imm, 1=4, 2=zero.
- out_rd  out  REG_IDX_W  destination register.
- out_wen  out  1  instruction writes rd.
- out_ebreak  out  1  ebreak decoded.
- out_illegal  out  1  unsupported encoding.

Behaviour:
- Reset (async): all out_* = 0, busy[] = 0, all GPRs = 0.
  - Reset mid-stall or mid-handshake discards the held instruction.
- Decode table:
  - addi (opc 0010011, f3 000): L=0, R=0, I-type imm, wen=1.
  - lui (0110111): L=2, R=0, U-imm.
  - auipc (0010111): L=1, R=0, U-imm.
  - jal (1101111): L=1, R=1, J-imm.
  - jalr (1100111, f3 000): L=1, R=1, I-imm.
  - ebreak (exactly 0x00100073): ebreak=1, wen=0, L=2, R=2.
  - Anything else: illegal=1, wen=0, L=2, R=2, imm=0.
  - Immediates are sign-extended to DATA_WIDTH.
- rs1 is used only when L=0. rd=0 forces wen=0.
- hazard = (L==0 && busy[rs1]) || (wen && busy[rd]). The WAW check guarantees at most one outstanding writer per register, so one busy bit per register suffices.
- in_ready = (!out_valid || out_ready) && !hazard. Ready depends combinationally on out_ready.
- Accept = in_valid && in_ready. On accept, the output register loads next edge (latency 1 cycle); out_valid is set and busy[rd] is set if wen.
- Output register is held stable while out_valid && !out_ready.
- If no accept and out_ready is high, out_valid clears.
- wb_en && wb_rd!=0 writes the GPR and clears busy[wb_rd] at the edge.
  - Simultaneous clear and set of the same index (only possible without a hazard when they differ) cannot collide because of the WAW stall.
  - Writes to x0 are ignored.
- GPR read is combinational. A write takes effect at the edge, so same-cycle reads return the old value, except as stated under the optional feature.

Optional Feature:
IDU_WB_BYPASS_EN:
- Defined: a same-cycle wb_en with wb_rd==rs1 (rs1!=0) removes the rs1 term of the hazard. out_src1 captures wb_data, giving zero-cycle RAW resolution.
- Undefined: the instruction stalls that cycle and captures the GPR value on the following cycle (one extra bubble).

Decomposition:
- Shared package holds:
  - opcode/funct3 constants and EBREAK_INST;
  - left-select encodings LSEL_SRC1/LSEL_PC/LSEL_ZERO;
  - right-select encodings RSEL_IMM/RSEL_FOUR/RSEL_ZERO;
  - imm-type enum (I/U/J).
- One sub-module, gpr_file: 1 read, 1 write, async reset, x0 hardwired.
- Decode logic and scoreboard stay in the top module.

Test Plan:
- Reset; addi x1,x0,5 (0x00500093), pc=0x80000000 → next cycle: out_valid=1, src1=0, imm=5, L=0, R=0, rd=1, wen=1, busy[1]=1.
- lui x2,0x12345 (0x12345137) → imm=0x12345000, L=2, R=0, rd=2; auipc x3,1 (0x00001197), pc=0x80000004 → L=1, imm=0x1000, out_pc=0x80000004.
- After the addi x1 above, present addi x3,x1,1 (0x00108193) → in_ready=0. Then wb_en, rd=1, data=5:
  - with IDU_WB_BYPASS_EN: accepted that cycle, src1=5;
  - without: accepted next cycle, src1=5.
- out_ready=0 for 3 cycles with in_valid=1 → outputs unchanged and in_ready=0; out_ready=1 → next instruction loads on the following edge with no loss or duplication.
- jal x1,8 (0x008000ef), pc=0x80000010 → L=1, R=1, imm=8, pc=0x80000010. Then ebreak (0x00100073) → ebreak=1, wen=0. Then 0xffffffff → illegal=1, wen=0.
- wb_en to x0 with data 0xdead → a later read of x0 gives 0. Assert rst during a RAW stall → out_valid=0, busy cleared, and the stalled instruction is accepted on the first cycle after reset release.
